game_timer: RTL

- Countdown timer stage directly downstream of the game-difficulty FSM; consumes its playHard/playMedium/playEasy/externalReset outputs.
- On a valid difficulty selection, loads a per-difficulty time budget and counts down in seconds while the player navigates the maze.
- Reports a win when the maze logic signals the exit was reached, or a timeout when the budget expires.
- Outputs feed the score/HUD display and the game-over screen logic.

---
 rtl/game_timer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/game_timer.sv
// game_timer: per-difficulty countdown stage. Loads a time budget when exactly
// one play* level is selected, counts down in one-second ticks, and reports a
// win (exit reached) or a timeout (budget expired).
module game_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int HARD_TIME     = 30,
  parameter int MED_TIME      = 60,
  parameter int EASY_TIME     = 90,
  parameter int TIME_W        = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              playHard,
  input  logic              playMedium,
  input  logic              playEasy,
  input  logic              externalReset,
  input  logic              reachedExit,
  input  logic              pause,
  output logic [TIME_W-1:0] timeLeft,
  output logic              running,
  output logic              secPulse,
  output logic              won,
  output logic              timedOut
);

  localparam int PRE_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WIN, S_TIMEOUT} state_t;
  // L_NONE stands for "no valid selection" (zero or several levels high).
  typedef enum logic [1:0] {L_NONE, L_HARD, L_MED, L_EASY} level_t;

  state_t             state_q, state_d;
  level_t             lvl_q, lvl_d, level_in;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TIME_W-1:0]  tl_q, tl_d, budget;
  logic               sp_q, sp_d;
  logic               any_play;

  // Decode the difficulty inputs into a single level and its time budget.
  always_comb begin
    level_in = L_NONE;
    budget   = '0;
    case ({playHard, playMedium, playEasy})
      3'b100:  begin level_in = L_HARD; budget = TIME_W'(HARD_TIME); end
      3'b010:  begin level_in = L_MED;  budget = TIME_W'(MED_TIME);  end
      3'b001:  begin level_in = L_EASY; budget = TIME_W'(EASY_TIME); end
      default: begin level_in = L_NONE; budget = '0;                 end
    endcase
  end

  assign any_play = playHard | playMedium | playEasy;

  // State register and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      lvl_q   <= L_NONE;
      pre_q   <= '0;
      tl_q    <= '0;
      sp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      lvl_q   <= lvl_d;
      pre_q   <= pre_d;
      tl_q    <= tl_d;
      sp_q    <= sp_d;
    end
  end

  // Next-state and next-datapath logic; externalReset overrides everything.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    lvl_d   = lvl_q;
    pre_d   = pre_q;
    tl_d    = tl_q;
    sp_d    = 1'b0;
    if (externalReset) begin
      state_d = S_IDLE;
      pre_d   = '0;
      tl_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_in != L_NONE) begin
            state_d = S_RUN;
            lvl_d   = level_in;
            tl_d    = budget;
            pre_d   = '0;
          end
        end
        S_RUN: begin
          // A dropped level, a different level or an invalid mix all differ
          // from the level latched at entry.
          if (level_in != lvl_q) begin
            state_d = S_IDLE;
          end else if (reachedExit) begin
            state_d = S_WIN;
          end else if (!pause) begin
            if (pre_q == PRE_TERM) begin
              pre_d = '0;
              if (tl_q != '0) begin
                tl_d = tl_q - TIME_W'(1);
                sp_d = 1'b1;
                if (tl_q == TIME_W'(1)) state_d = S_TIMEOUT;
              end
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
          end
        end
        S_WIN, S_TIMEOUT: begin
          if (!any_play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign timeLeft = tl_q;
  assign secPulse = sp_q;
  assign running  = (state_q == S_RUN);
  assign won      = (state_q == S_WIN);
  assign timedOut = (state_q == S_TIMEOUT);

endmodule
